// File: rtl/msk_ref_rnd_prng.sv
`default_nettype none
// ============================================================================
// Module   : msk_ref_rnd_prng
// Purpose  : Seeded pseudo-random source for masked refresh gadgets. A 64-bit
//            Fibonacci LFSR (x^64 + x^63 + x^61 + x^60 + 1) is loaded from an
//            8-byte serial seed. It then discards WARMUP cycles of output and
//            finally delivers NR fresh bits per handshake on rnd.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   d          masking order of the driven refresh gadget (2..5)
//   WARMUP     discard cycles after seeding (1..255)
//   NR         derived output width (d=2:1, d=3:2, d=4:4, d=5:5)
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   seed_in    seed byte; the first byte accepted ends up in s[63:56]
//   seed_valid seed byte offered
//   seed_ready seed byte can be accepted (IDLE, LOAD or RUN, not in reset)
//   rnd        NR random bits; rnd[0] is the oldest generated bit
//   rnd_valid  rnd holds fresh, unconsumed bits
//   rnd_ready  consumer takes rnd this cycle
//   busy       block is loading a seed or warming up
// ============================================================================
module msk_ref_rnd_prng #(
    parameter  int d      = 2,
    parameter  int WARMUP = 128,
    localparam int NR     = (d == 2) ? 1 :
                            (d == 3) ? 2 :
                            (d == 4) ? 4 : 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    seed_in,
    input  logic          seed_valid,
    output logic          seed_ready,
    output logic [NR-1:0] rnd,
    output logic          rnd_valid,
    input  logic          rnd_ready,
    output logic          busy
);

    // Last value of the warm-up counter before the block enters RUN.
    localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t        state_q;
    logic [63:0]   s_q;
    logic [2:0]    byte_cnt_q;
    logic [7:0]    warm_cnt_q;
    logic [NR-1:0] rnd_q;
    logic          rnd_valid_q;

    // Next-state candidates computed from the current register contents.
    logic [63:0]   s_load_d;    // state with the offered seed byte shifted in
    logic [63:0]   s_adv_d;     // state advanced by NR LFSR steps
    logic [NR-1:0] rnd_next_d;  // the NR feedback bits produced by those steps
    logic          seed_fire;

    // ------------------------------------------------------------------------
    // Handshake decode. seed_ready and busy come straight from the state
    // register; gating with rst keeps both low while reset is held, which
    // matters on the very first reset cycle when the state is still unknown.
    // ------------------------------------------------------------------------
    assign seed_ready = !rst && (state_q != ST_WARMUP);
    assign busy       = !rst && ((state_q == ST_LOAD) || (state_q == ST_WARMUP));
    assign seed_fire  = seed_valid && seed_ready;

    assign rnd        = rnd_q;
    assign rnd_valid  = rnd_valid_q;

    assign s_load_d   = {s_q[55:0], seed_in};

    // ------------------------------------------------------------------------
    // NR LFSR steps unrolled within one cycle. Each step shifts left and
    // appends the feedback bit, so rnd_next_d[0] is the first generated bit
    // and rnd_next_d[NR-1] the last.
    // ------------------------------------------------------------------------
    always_comb begin
        s_adv_d    = s_q;
        rnd_next_d = '0;
        for (int i = 0; i < NR; i++) begin
            rnd_next_d[i] = s_adv_d[63] ^ s_adv_d[62] ^ s_adv_d[60] ^ s_adv_d[59];
            s_adv_d       = {s_adv_d[62:0], rnd_next_d[i]};
        end
    end

    // ------------------------------------------------------------------------
    // Control state machine with all datapath registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            byte_cnt_q  <= '0;
            warm_cnt_q  <= '0;
            rnd_q       <= '0;
            rnd_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (seed_fire) begin
                        s_q        <= s_load_d;
                        byte_cnt_q <= 3'd1;
                        state_q    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    // With seed_valid low, everything holds indefinitely.
                    if (seed_fire) begin
                        if (byte_cnt_q == 3'd7) begin
                            // All-zero is the LFSR lock-up state; substitute
                            // the smallest non-zero seed.
                            s_q        <= (s_load_d == 64'h0) ? 64'h1 : s_load_d;
                            byte_cnt_q <= '0;
                            warm_cnt_q <= '0;
                            state_q    <= ST_WARMUP;
                        end else begin
                            s_q        <= s_load_d;
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                    end
                end

                ST_WARMUP: begin
                    s_q        <= s_adv_d;
                    warm_cnt_q <= warm_cnt_q + 8'd1;
                    if (warm_cnt_q == WARM_LAST) begin
                        state_q <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (seed_fire) begin
                        // Reseed wins over consumption. rnd keeps its last
                        // value, but it is no longer marked valid.
                        s_q         <= s_load_d;
                        byte_cnt_q  <= 3'd1;
                        rnd_valid_q <= 1'b0;
                        state_q     <= ST_LOAD;
                    end else if (!rnd_valid_q || rnd_ready) begin
                        // Fill an empty output, or refill a consumed one.
                        s_q         <= s_adv_d;
                        rnd_q       <= rnd_next_d;
                        rnd_valid_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_msk_ref_rnd_prng.sv
`default_nettype none
// ============================================================================
// Module   : tb_msk_ref_rnd_prng
// Purpose  : Bench for msk_ref_rnd_prng. Four instances (d = 2..5) share one
//            stimulus stream. A stream-level model holds a software LFSR per
//            instance and the seed/warm-up/run protocol; the DUT outputs are
//            compared against it on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msk_ref_rnd_prng;

    localparam int WARMUP = 128;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seed_in;
    logic       seed_valid;
    logic       rnd_ready;

    logic [3:0] srdy;
    logic [3:0] vld;
    logic [3:0] bsy;
    logic [0:0] rnd2;
    logic [1:0] rnd3;
    logic [3:0] rnd4;
    logic [4:0] rnd5;
    logic [4:0] rnd_all [4];

    assign rnd_all[0] = {4'b0, rnd2};
    assign rnd_all[1] = {3'b0, rnd3};
    assign rnd_all[2] = {1'b0, rnd4};
    assign rnd_all[3] = rnd5;

    always #5 clk = ~clk;

    msk_ref_rnd_prng #(.d(2), .WARMUP(WARMUP)) u_d2 (
        .clk(clk), .rst(rst), .seed_in(seed_in), .seed_valid(seed_valid),
        .seed_ready(srdy[0]), .rnd(rnd2), .rnd_valid(vld[0]),
        .rnd_ready(rnd_ready), .busy(bsy[0]));
    msk_ref_rnd_prng #(.d(3), .WARMUP(WARMUP)) u_d3 (
        .clk(clk), .rst(rst), .seed_in(seed_in), .seed_valid(seed_valid),
        .seed_ready(srdy[1]), .rnd(rnd3), .rnd_valid(vld[1]),
        .rnd_ready(rnd_ready), .busy(bsy[1]));
    msk_ref_rnd_prng #(.d(4), .WARMUP(WARMUP)) u_d4 (
        .clk(clk), .rst(rst), .seed_in(seed_in), .seed_valid(seed_valid),
        .seed_ready(srdy[2]), .rnd(rnd4), .rnd_valid(vld[2]),
        .rnd_ready(rnd_ready), .busy(bsy[2]));
    msk_ref_rnd_prng #(.d(5), .WARMUP(WARMUP)) u_d5 (
        .clk(clk), .rst(rst), .seed_in(seed_in), .seed_valid(seed_valid),
        .seed_ready(srdy[3]), .rnd(rnd5), .rnd_valid(vld[3]),
        .rnd_ready(rnd_ready), .busy(bsy[3]));

    // ---------------- reference model state ----------------
    int          n_tests;
    int          n_fail;
    bit          m_live;
    bit          m_loading;
    bit          m_warming;
    bit          m_running;
    bit          m_valid;
    int          m_nb;
    int          m_warm_left;
    logic [63:0] m_acc;
    logic [63:0] ms [4];
    logic [4:0]  m_rnd [4];

    function automatic int nr_of(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 5;
        endcase
    endfunction

    // Polynomial x^64+x^63+x^61+x^60+1 in Fibonacci form.
    function automatic logic fb(input logic [63:0] s);
        return s[63] ^ s[62] ^ s[60] ^ s[59];
    endfunction

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return {s[62:0], fb(s)};
    endfunction

    task automatic chk(input string name, input int k,
                       input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (inst %0d) at %0t: got %0h, expected %0h",
                     name, k, $time, act, exp);
        end
    endtask

    // New seed: apply the zero guard, then drop the warm-up bits in one go.
    task automatic reseed(input logic [63:0] seed);
        for (int k = 0; k < 4; k++) begin
            ms[k] = (seed == 64'h0) ? 64'h1 : seed;
            for (int j = 0; j < nr_of(k) * WARMUP; j++) ms[k] = lfsr_step(ms[k]);
        end
    endtask

    task automatic draw_words();
        for (int k = 0; k < 4; k++) begin
            m_rnd[k] = '0;
            for (int j = 0; j < nr_of(k); j++) begin
                m_rnd[k][j] = fb(ms[k]);
                ms[k]       = lfsr_step(ms[k]);
            end
        end
    endtask

    // Protocol-level model update, evaluated on each rising edge from the
    // inputs that were stable before it.
    task automatic model_loop();
        forever begin
            @(posedge clk);
            if (rst) begin
                m_live      = 1'b1;
                m_loading   = 1'b0;
                m_warming   = 1'b0;
                m_running   = 1'b0;
                m_valid     = 1'b0;
                m_nb        = 0;
                m_warm_left = 0;
                for (int k = 0; k < 4; k++) m_rnd[k] = '0;
            end else if (m_live) begin
                if (m_warming) begin
                    m_warm_left--;
                    if (m_warm_left == 0) begin
                        m_warming = 1'b0;
                        m_running = 1'b1;
                    end
                end else if (seed_valid) begin
                    m_acc     = {m_acc[55:0], seed_in};
                    m_running = 1'b0;
                    m_valid   = 1'b0;
                    m_nb      = m_loading ? m_nb + 1 : 1;
                    m_loading = 1'b1;
                    if (m_nb == 8) begin
                        m_loading   = 1'b0;
                        m_warming   = 1'b1;
                        m_warm_left = WARMUP;
                        reseed(m_acc);
                    end
                end else if (m_running && (!m_valid || rnd_ready)) begin
                    draw_words();
                    m_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (m_live) begin
                for (int k = 0; k < 4; k++) begin
                    chk("rnd", k, 64'(rnd_all[k]), 64'(m_rnd[k]));
                    chk("rnd_valid", k, 64'(vld[k]), 64'(m_valid));
                    chk("busy", k, 64'(bsy[k]), 64'(!rst && (m_loading || m_warming)));
                    chk("seed_ready", k, 64'(srdy[k]), 64'(!rst && !m_warming));
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers seed bytes first..last (byte 0 = seed[63:56]) with random gaps
    // in which seed_in carries junk.
    task automatic load_bytes(input logic [63:0] seed, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            seed_in    = seed[63 - 8 * i -: 8];
            seed_valid = 1'b1;
            tick();
            seed_valid = 1'b0;
            if (i < last) begin
                repeat ($urandom_range(0, 3)) begin
                    seed_in = 8'($urandom);
                    tick();
                end
            end
        end
    endtask

    // Counts edges from the one accepting byte 8 until every rnd_valid is high.
    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (vld !== 4'hF && n < WARMUP + 50) begin
            tick();
            n++;
        end
        chk(name, -1, 64'(n), 64'(WARMUP + 1));
    endtask

    task automatic check_idle(input string name);
        chk({name, "_seed_ready"}, -1, 64'(srdy), 64'(4'hF));
        chk({name, "_busy"}, -1, 64'(bsy), 64'(4'h0));
        chk({name, "_rnd_valid"}, -1, 64'(vld), 64'(4'h0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] s;
        logic [59:0] v60;
        logic [59:0] pin60;
        logic [1:0]  v2;
        logic [63:0] golden;
        logic [63:0] newseed;

        rst        = 1'b1;
        seed_in    = 8'h00;
        seed_valid = 1'b0;
        rnd_ready  = 1'b0;
        n_tests    = 0;
        n_fail     = 0;
        m_live     = 1'b0;
        m_loading  = 1'b0;
        m_warming  = 1'b0;
        m_running  = 1'b0;
        m_valid    = 1'b0;
        m_nb       = 0;
        m_warm_left = 0;
        m_acc      = '0;
        for (int k = 0; k < 4; k++) begin
            ms[k]    = '0;
            m_rnd[k] = '0;
        end
        golden = 64'h0123_4567_89AB_CDEF;

        // Hand-derived pins of the model LFSR: from seed 1 the single set bit
        // must climb to position 59 before the first 1 is fed back (bit 60).
        s = 64'h1;
        for (int j = 0; j < 60; j++) begin
            v60[j] = fb(s);
            s      = lfsr_step(s);
        end
        pin60 = 60'h800_0000_0000_0000;
        chk("model_pin_seed1", -1, 64'(v60), 64'(pin60));
        // Taps 63,62,60 set and 59 clear: first bit 1; then bit 60 becomes 0.
        s = 64'hF000_0000_0000_0000;
        v2[0] = fb(s);
        s     = lfsr_step(s);
        v2[1] = fb(s);
        chk("model_pin_taps", -1, 64'(v2), 64'(2'b01));

        fork
            model_loop();
            compare_loop();
        join_none

        // Reset held for three cycles.
        repeat (3) begin
            tick();
            chk("reset_seed_ready", -1, 64'(srdy), 64'(4'h0));
            chk("reset_busy", -1, 64'(bsy), 64'(4'h0));
            chk("reset_rnd_valid", -1, 64'(vld), 64'(4'h0));
            for (int k = 0; k < 4; k++) chk("reset_rnd", k, 64'(rnd_all[k]), 64'h0);
        end
        rst = 1'b0;
        #1;
        check_idle("release");
        repeat (3) tick();
        check_idle("idle");

        // Golden seed with gaps, then an unstalled run.
        rnd_ready = 1'b1;
        load_bytes(golden, 0, 7);
        wait_valid("golden_latency");
        repeat (1000) tick();

        // Random back-pressure.
        repeat (400) begin
            rnd_ready = 1'($urandom_range(0, 1));
            tick();
        end
        rnd_ready = 1'b1;
        tick();

        // Reseed abort with rnd_ready high.
        newseed = {32'($urandom), 32'($urandom)};
        seed_in    = newseed[63:56];
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        chk("abort_rnd_valid", -1, 64'(vld), 64'(4'h0));
        chk("abort_busy", -1, 64'(bsy), 64'(4'hF));
        load_bytes(newseed, 1, 7);
        wait_valid("abort_latency");
        repeat (200) tick();

        // All-zero seed (first byte also aborts RUN); stalls keep it varied.
        load_bytes(64'h0, 0, 7);
        wait_valid("zero_latency");
        repeat (300) begin
            rnd_ready = 1'($urandom_range(0, 1));
            tick();
        end
        rnd_ready = 1'b1;

        // Reset after four LOAD bytes.
        load_bytes(golden, 0, 3);
        chk("midload_busy", -1, 64'(bsy), 64'(4'hF));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_idle("rst_in_load");

        // Reset in WARMUP.
        load_bytes(golden, 0, 7);
        repeat (50) tick();
        chk("warmup_seed_ready", -1, 64'(srdy), 64'(4'h0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_idle("rst_in_warmup");

        // Fresh load reproduces the golden stream.
        load_bytes(golden, 0, 7);
        wait_valid("reload_latency");
        repeat (300) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/msk_ref_rnd_prng.md
# msk_ref_rnd_prng

Seeded pseudo-random source for the masked refresh gadgets. It produces the `ref_n_rnd` fresh random bits per cycle that the SNI refresh gadget consumes on its `rnd` input. The block uses a 64-bit Fibonacci LFSR, loaded from an 8-byte serial seed, followed by a fixed warm-up phase. One instance sits directly upstream of each refresh gadget, or of a bank of gadgets via slicing.

## Interface

Parameters:
- `d`, default 2: masking order of the driven refresh gadget; legal values 2..5.
- `NR`, derived, not overridable: output width. d=2 gives 1, d=3 gives 2, d=4 gives 4, d=5 gives 5. This equals the gadget's `ref_n_rnd`.
- `WARMUP`, default 128: number of discard cycles after seeding; legal range 1..255.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `seed_in` in 8: seed byte.
- `seed_valid` in 1: seed byte offered.
- `seed_ready` out 1: seed byte can be accepted.
- `rnd` out NR: random bits; connects to the gadget `rnd`.
- `rnd_valid` out 1: `rnd` holds fresh, unconsumed bits.
- `rnd_ready` in 1: consumer takes `rnd` this cycle.
- `busy` out 1: block is in LOAD or WARMUP.

## Operation

State machine:
- States: IDLE (unseeded), LOAD, WARMUP, RUN.
- IDLE: `seed_ready`=1, `rnd_valid`=0. An accepted byte moves the block to LOAD with byte count 1.
- LOAD: `seed_ready`=1. Each accepted byte shifts in as `s <= {s[55:0], seed_in}`, so the first byte ends in `s[63:56]`. When the 8th byte is accepted, the block moves to WARMUP and clears the counter.
- WARMUP: `seed_ready`=0. The state advances NR steps per cycle and the counter increments. When the counter reaches WARMUP-1, the block moves to RUN.
- RUN: `seed_ready`=1. A `seed_valid` handshake in RUN aborts output: the block moves to LOAD with that byte as byte 1. `rnd_valid` falls on that same edge, and the remaining state bits keep shifting as in LOAD.

LFSR step:
- Feedback bit: `f = s[63]^s[62]^s[60]^s[59]`, from the polynomial x^64+x^63+x^61+x^60+1.
- Update: `s <= {s[62:0], f}`.
- NR steps are unrolled combinationally within one cycle. `rnd[0]` is the first bit generated and `rnd[NR-1]` the last.

Zero-seed guard:
- If the state is all-zero at the LOAD->WARMUP transition, it is replaced by 64'h1.
- The stream is therefore identical to that of seed 64'h1.

RUN output:
- On every cycle with `rnd_valid && rnd_ready`, `rnd` is reloaded with the next NR bits and the state advances NR steps.
- Without `rnd_ready`, `rnd` and the state hold. No bit is ever presented twice as valid.

Reset:
- `rst` in any state forces IDLE and clears the LOAD byte count and WARMUP counter.
- Reset values: `s`=0, `rnd`=0, `rnd_valid`=0, `seed_ready`=0 while `rst`=1 (1 on the first cycle after release), `busy`=0.
- A partially loaded seed is discarded on reset.

## Timing

- All outputs are registered except `seed_ready` and `busy`, which are decoded from the registered state.
- Let E0 be the edge that accepts the 8th seed byte. WARMUP spans edges E1..E(WARMUP), and the state is stepped NR times at each.
- At E(WARMUP+1), `rnd` is loaded with the first output bits and `rnd_valid` rises.
- With the default WARMUP, `rnd_valid` is high after edge E129.
- Throughput in RUN: NR bits per cycle with `rnd_ready` held at 1. There are no bubbles.
- Reseed abort: `rnd_valid` is low after the edge that accepts the abort byte. `rnd` holds its last value; it is not cleared.
- Simultaneous `seed_valid` and `rnd_ready` in RUN: the seed takes priority, and `rnd` is not reloaded.
- Back-pressure in LOAD: with `seed_valid`=0, the state and byte count hold, with no timeout.

## Test plan

- Reset and idle check. With d=2, assert `rst` for 3 cycles, then release. Expect `rnd`=0, `rnd_valid`=0 and `busy`=0 throughout. `seed_ready` is 0 during reset and 1 after release.
- Golden stream for d=4. Load seed bytes 01 23 45 67 89 AB CD EF with gaps in `seed_valid`. Expect `rnd_valid` to rise exactly 129 edges after byte 8. Then compare 1000 consecutive `rnd` words against a software LFSR model: 4 steps per word, `rnd[0]` first, 4×128 bits discarded beforehand.
- Zero seed. Load eight 00 bytes with d=5. The output stream must be bit-identical to the stream produced from seed 00..00 01.
- Back-pressure for d=3. Toggle `rnd_ready` pseudo-randomly in RUN. The concatenation of handshaked `rnd` words must equal the unstalled model stream, and `rnd` must be stable while `rnd_ready`=0.
- Reseed abort. In RUN, offer a new seed byte while `rnd_ready`=1. Expect `rnd_valid`=0 and `busy`=1 after that edge and no `rnd` update. After the remaining 7 bytes plus warm-up, the stream matches the model for the new seed.
- Reset mid-operation. Assert `rst` after 4 LOAD bytes, then once during WARMUP. Each time, expect a return to IDLE with `rnd_valid`=0. A fresh 8-byte load afterwards must reproduce the golden stream exactly.
